// File: rtl/riscv_imem_responder_if.sv
// riscv_imem_responder_if: fetch handshake and program-load port of the instruction memory responder.
interface riscv_imem_responder_if #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10
);
    logic req;
    logic [BUS_WIDTH-1:0] addr;
    logic busy;
    logic valid;
    logic [BUS_WIDTH-1:0] data;
    logic err;
    logic we;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [BUS_WIDTH-1:0] wdata;
    modport master (output req, addr, we, waddr, wdata, input busy, valid, data, err);
    modport slave (input req, addr, we, waddr, wdata, output busy, valid, data, err);
endinterface

// File: rtl/riscv_imem_responder.sv
// riscv_imem_responder: instruction memory with fixed wait states, fault flagging and a program-load port.
// Define RISCV_IMEM_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module riscv_imem_responder #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_STATES = 2,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR = '0
) (
    input logic clk,
    input logic rst_n,
    riscv_imem_responder_if.slave bus
);
    localparam logic [BUS_WIDTH-1:0] NOP = BUS_WIDTH'(32'h0000_0013);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [BUS_WIDTH-1:0] addr_q, raddr, data, hit_data;
    logic [BUS_WIDTH-2:0] diff;
    logic [DEPTH_LOG2-1:0] idx;
    logic [BUS_WIDTH-1:0] mem [2**DEPTH_LOG2];
    logic busy, valid, err, accept, hit, fault, go_resp, go_wait;
    assign bus.busy = busy;
    assign bus.valid = valid;
    assign bus.data = data;
    assign bus.err = err;
    assign accept = bus.req && !busy;
    // A WAIT_STATES=0 or prefetch-hit fetch reads on the accept edge, before addr_q is loaded.
    assign raddr = accept ? bus.addr : addr_q;
    assign diff = {1'b0, raddr[BUS_WIDTH-1:2]} - {1'b0, BASE_ADDR[BUS_WIDTH-1:2]};
    assign idx = diff[DEPTH_LOG2-1:0];
    assign fault = raddr[1:0] != 2'b00 || diff[BUS_WIDTH-2] || diff[BUS_WIDTH-3:DEPTH_LOG2] != '0;
    assign go_resp = (state == WAIT && cnt == '0) || (accept && (WAIT_STATES == 0 || hit));
    assign go_wait = accept && !go_resp;
    always_ff @(posedge clk)
        if (bus.we) mem[bus.waddr] <= bus.wdata;
`ifdef RISCV_IMEM_PREFETCH_EN
    logic [BUS_WIDTH-1:0] pf_addr, pf_data;
    logic [DEPTH_LOG2-1:0] pf_idx;
    logic pf_valid;
    assign hit = accept && pf_valid && bus.addr == pf_addr;
    assign hit_data = pf_data;
    // The buffer is refilled on every RESP entry, so a same-edge write to the next word must invalidate it.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pf_valid <= 1'b0;
            pf_addr <= '0;
            pf_idx <= '0;
            pf_data <= '0;
        end else if (go_resp) begin
            pf_addr <= raddr + BUS_WIDTH'(4);
            pf_idx <= idx + 1'b1;
            pf_data <= mem[idx + 1'b1];
            pf_valid <= !fault && idx != '1 && !(bus.we && bus.waddr == idx + 1'b1);
        end else if (bus.we && bus.waddr == pf_idx) begin
            pf_valid <= 1'b0;
        end
`else
    assign hit = 1'b0;
    assign hit_data = '0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            busy <= 1'b0;
            valid <= 1'b0;
            err <= 1'b0;
            data <= '0;
        end else begin
            if (accept) addr_q <= bus.addr;
            cnt <= go_wait ? WAIT_LOAD : (state == WAIT && cnt != '0) ? cnt - 1'b1 : cnt;
            state <= go_resp ? RESP : (go_wait || state == WAIT) ? WAIT : IDLE;
            busy <= go_wait || (state == WAIT && !go_resp);
            valid <= go_resp;
            if (go_resp) begin
                err <= fault;
                data <= fault ? NOP : hit ? hit_data : mem[idx];
            end
        end
endmodule

// File: tb/tb_riscv_imem_responder.sv
// tb_riscv_imem_responder: directed checks of latency, faults, reset abort, read-before-write
// and zero-wait-state streaming.
module tb_riscv_imem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
`ifdef RISCV_IMEM_PREFETCH_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_BSY = 0;
`else
    localparam int HIT_LAT = 3;
    localparam int HIT_BSY = 2;
`endif
    localparam logic [31:0] NOP = 32'h0000_0013;
    riscv_imem_responder_if #(.BUS_WIDTH(32), .DEPTH_LOG2(10)) bus ();
    riscv_imem_responder_if #(.BUS_WIDTH(32), .DEPTH_LOG2(10)) bus0 ();
    riscv_imem_responder #(.BUS_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(2), .BASE_ADDR(32'h0))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    riscv_imem_responder #(.BUS_WIDTH(32), .DEPTH_LOG2(10), .WAIT_STATES(0), .BASE_ADDR(32'h0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic drop();
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    // Leaves req high so consecutive calls model a requester holding i_REQ.
    task automatic fetch(input string tag, input logic [31:0] a, input int exp_lat,
                         input int exp_bsy, input logic [31:0] exp_d, input logic exp_e);
        int lat, nb;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.busy), 32'd0);
        bus.req = 1'b1;
        bus.addr = a;
        @(posedge clk);
        #1;
        lat = 1;
        nb = 0;
        while (!bus.valid && lat < 20) begin
            nb += int'(bus.busy);
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busy"}, 32'(nb), 32'(exp_bsy));
        chk({tag, "_data"}, bus.data, exp_d);
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_e));
    endtask

    initial begin
        int seen;
        logic [31:0] v0 [4];
        v0 = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        bus.req = 1'b0; bus.addr = '0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus0.req = 1'b0; bus0.addr = '0; bus0.we = 1'b0; bus0.waddr = '0; bus0.wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_data", bus.data, 32'd0);
        rst_n = 1'b1;
        wr(10'd0, 32'h0050_0093);
        wr(10'd1, 32'h0010_0113);
        wr(10'd2, 32'h0020_81b3);
        wr(10'd1023, 32'hdead_beef);
        // basic fetch, then outputs hold after the valid pulse
        fetch("t1", 32'h0, 3, 2, 32'h0050_0093, 1'b0);
        drop();
        @(posedge clk);
        #1;
        chk("t1_valid_pulse", 32'(bus.valid), 32'd0);
        chk("t1_data_hold", bus.data, 32'h0050_0093);
        // faults and last in-range word
        fetch("t2_misalign", 32'h2, 3, 2, NOP, 1'b1);
        fetch("t2_range", 32'h1000, 3, 2, NOP, 1'b1);
        fetch("t2_last", 32'hffc, 3, 2, 32'hdead_beef, 1'b0);
        drop();
        // held request streaming
        fetch("t3_a0", 32'h0, 3, 2, 32'h0050_0093, 1'b0);
        fetch("t3_a4", 32'h4, HIT_LAT, HIT_BSY, 32'h0010_0113, 1'b0);
        fetch("t3_a8", 32'h8, HIT_LAT, HIT_BSY, 32'h0020_81b3, 1'b0);
        drop();
        // reset while waiting drops the fetch
        @(negedge clk);
        bus.req = 1'b1;
        bus.addr = 32'h0;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk("t4_busy_wait", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_busy_rst", 32'(bus.busy), 32'd0);
        chk("t4_valid_rst", 32'(bus.valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            seen += int'(bus.valid);
        end
        chk("t4_no_resp", 32'(seen), 32'd0);
        fetch("t4_after", 32'h0, 3, 2, 32'h0050_0093, 1'b0);
        drop();
        // write on the edge entering RESP is not seen by that fetch
        @(negedge clk);
        bus.req = 1'b1;
        bus.addr = 32'h0;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        bus.we = 1'b1;
        bus.waddr = 10'd0;
        bus.wdata = 32'h00a0_0093;
        @(posedge clk);
        #1;
        chk("t5_valid", 32'(bus.valid), 32'd1);
        chk("t5_old", bus.data, 32'h0050_0093);
        @(negedge clk);
        bus.we = 1'b0;
        fetch("t5_new", 32'h0, 3, 2, 32'h00a0_0093, 1'b0);
        drop();
        wr(10'd1, 32'h0030_0193);
        fetch("t5_pfw", 32'h4, 3, 2, 32'h0030_0193, 1'b0);
        drop();
        // zero wait states: one fetch per cycle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus0.we = 1'b1;
            bus0.waddr = 10'(k);
            bus0.wdata = v0[k];
        end
        @(negedge clk);
        bus0.we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t6_busy%0d", k), 32'(bus0.busy), 32'd0);
            bus0.req = 1'b1;
            bus0.addr = 32'(4 * k);
            @(posedge clk);
            #1;
            chk($sformatf("t6_valid%0d", k), 32'(bus0.valid), 32'd1);
            chk($sformatf("t6_data%0d", k), bus0.data, v0[k]);
        end
        @(negedge clk);
        bus0.req = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_idle", 32'(bus0.valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
